// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, execute redirect and decode head.
// Latency: wiring only, no state.
// Backpressure: decode stall_d and memory imem_valid; master = fetch_queue side.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_valid;
  logic            redirect_e;
  logic [XLEN-1:0] redirect_pc_e;
  logic            stall_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus_4_d;
  logic            valid_d;
  logic [CW-1:0]   count;

  modport master (
    output imem_addr, instr_d, pc_d, pc_plus_4_d, valid_d, count,
    input  imem_rdata, imem_valid, redirect_e, redirect_pc_e, stall_d
  );

  modport slave (
    input  imem_addr, instr_d, pc_d, pc_plus_4_d, valid_d, count,
    output imem_rdata, imem_valid, redirect_e, redirect_pc_e, stall_d
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry {pc, instr} prefetch queue between instruction memory and decode.
// Latency: word fetched in cycle n is at the decode head in cycle n+1.
// Backpressure: decode stalls fill the queue; fetch PC holds only when full without a pop.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] last_pc;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic valid;
  logic pop;
  logic push;

  assign valid = (count_q != '0);
  assign pop   = valid & ~bus.stall_d;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push  = bus.imem_valid & ~bus.redirect_e & ((count_q < CW'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      last_pc  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else if (bus.redirect_e) begin
      fetch_pc <= {bus.redirect_pc_e[XLEN-1:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        last_pc <= pc_mem[rd_ptr];
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_addr   = fetch_pc;
  assign bus.valid_d     = valid;
  assign bus.count       = count_q;
  assign bus.instr_d     = valid ? instr_mem[rd_ptr] : NOP;
  assign bus.pc_d        = valid ? pc_mem[rd_ptr] : last_pc;
  assign bus.pc_plus_4_d = bus.pc_d + XLEN'(4);
endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue against a queue-based reference model.
// Latency: n/a.  Backpressure: n/a.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the queue holds fetched PCs in program order.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0;
    m_last = 32'h0;
  endtask

  task automatic model_check();
    logic [31:0] exp_pc;
    exp_pc = (m_q.size() != 0) ? m_q[0] : m_last;
    chk("m_addr",  bus.imem_addr, m_pc);
    chk("m_valid", 32'(bus.valid_d), 32'(m_q.size() != 0));
    chk("m_count", 32'(bus.count), 32'(m_q.size()));
    chk("m_pc_d",  bus.pc_d, exp_pc);
    chk("m_pc4",   bus.pc_plus_4_d, exp_pc + 32'd4);
    chk("m_instr", bus.instr_d, (m_q.size() != 0) ? mem_word(m_q[0]) : NOP);
  endtask

  task automatic model_step(input logic iv, input logic red, input logic [31:0] rpc,
                            input logic st);
    bit do_pop;
    bit do_push;
    if (red) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      do_pop  = (m_q.size() != 0) && !st;
      do_push = iv && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) m_last = m_q.pop_front();
      if (do_push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Called 1 ns after a rising edge with inputs already driven.
  task automatic cycle();
    logic iv, red, st;
    logic [31:0] rpc;
    iv = bus.imem_valid; red = bus.redirect_e; rpc = bus.redirect_pc_e; st = bus.stall_d;
    #1;
    model_check();
    @(posedge clk);
    model_step(iv, red, rpc, st);
    #1;
  endtask

  task automatic drive(input logic iv, input logic st, input logic red, input logic [31:0] rpc);
    bus.imem_valid    = iv;
    bus.stall_d       = st;
    bus.redirect_e    = red;
    bus.redirect_pc_e = rpc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev_pc;
    logic [31:0] exp_addr [4];
    logic        exp_vld  [4];
    logic        iv_seq   [4];

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    model_reset();
    chk("rst_valid", 32'(bus.valid_d), 32'd0);
    chk("rst_instr", bus.instr_d, NOP);
    chk("rst_pc_d",  bus.pc_d, 32'h0);
    chk("rst_pc4",   bus.pc_plus_4_d, 32'h4);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming from reset
    chk("t1_addr0", bus.imem_addr, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("t1_addr",  bus.imem_addr, 32'(4 * i));
      chk("t1_valid", 32'(bus.valid_d), 32'd1);
      chk("t1_pc_d",  bus.pc_d, 32'(4 * (i - 1)));
      chk("t1_count", 32'(bus.count), 32'd1);
    end

    // Stall from empty, then drain in order
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk("t2_count", 32'(bus.count), 32'(k < 4 ? k : 4));
      chk("t2_head",  bus.pc_d, 32'h0);
    end
    chk("t2_addr", bus.imem_addr, 32'h10);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k <= 4; k++) begin
      chk("t2_pop_pc", bus.pc_d, 32'(4 * k));
      cycle();
    end

    // Full queue with simultaneous push/pop across pointer wrap
    prev_pc = bus.pc_d - 32'd4;
    for (int k = 0; k < 10; k++) begin
      chk("t3_count", 32'(bus.count), 32'd4);
      chk("t3_pc_d",  bus.pc_d, prev_pc + 32'd4);
      prev_pc = bus.pc_d;
      cycle();
    end

    // Memory wait states
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    cycle();
    iv_seq   = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_addr = '{32'h4, 32'h4, 32'h4, 32'h8};
    exp_vld  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive(iv_seq[k], 1'b0, 1'b0, 32'h0);
      cycle();
      chk("t4_addr",  bus.imem_addr, exp_addr[k]);
      chk("t4_valid", 32'(bus.valid_d), 32'(exp_vld[k]));
    end
    chk("t4_pc_d4", bus.pc_d, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("t4_pc_d8", bus.pc_d, 32'h8);

    // Misaligned redirect while stalled with three entries
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) cycle();
    chk("t5_count3", 32'(bus.count), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    cycle();
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_valid", 32'(bus.valid_d), 32'd0);
    chk("t5_instr", bus.instr_d, NOP);
    chk("t5_addr",  bus.imem_addr, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    cycle();
    chk("t5_valid1", 32'(bus.valid_d), 32'd1);
    chk("t5_pc_d",   bus.pc_d, 32'h100);

    // Back-to-back redirects: last one wins
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    cycle();
    chk("t6_addr", bus.imem_addr, 32'h40);

    // Asynchronous reset with three entries queued
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) cycle();
    chk("t7_count3", 32'(bus.count), 32'd3);
    rst = 1'b0;
    #1;
    model_reset();
    chk("t7_valid", 32'(bus.valid_d), 32'd0);
    chk("t7_addr",  bus.imem_addr, 32'h0);
    chk("t7_count", 32'(bus.count), 32'd0);
    chk("t7_instr", bus.instr_d, NOP);
    #4;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("t7_resume", bus.pc_d, 32'h0);
    chk("t7_rvalid", 32'(bus.valid_d), 32'd1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0, $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch stage that replaces the single fetch/decode pipeline register with a DEPTH-entry instruction prefetch queue.
- Generates the fetch PC and drives the instruction-memory address. It accepts instruction words with a valid handshake, so memory may insert wait states.
- Buffers {pc, instr} pairs and presents the queue head to decode with a valid flag.
- Absorbs decode stalls without stalling fetch until full. Flushes on an execute-stage redirect (taken branch/jump).

Parameters:
XLEN, 32, data/address width in bits
DEPTH, 4, queue entries (power of two, >= 2)
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP, 32'h0000_0013, instr_d value driven while valid_d = 0

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
imem_addr  output  XLEN  current fetch PC to instruction memory
imem_rdata  input  32  instruction word for imem_addr, same cycle
imem_valid  input  1  imem_rdata valid this cycle (0 = wait state)
redirect_e  input  1  taken branch/jump from execute
redirect_pc_e  input  XLEN  target PC for redirect
stall_d  input  1  decode cannot accept the head entry this cycle
instr_d  output  32  head instruction (NOP when valid_d = 0)
pc_d  output  XLEN  head entry PC
pc_plus_4_d  output  XLEN  pc_d + 4, modulo 2^XLEN
valid_d  output  1  head entry valid
count  output  $clog2(DEPTH+1)  current occupancy, for hazard unit/debug

Behaviour:
- Reset (rst = 0, async):
  - fetch PC = RESET_PC; count = 0; read/write pointers = 0.
  - valid_d = 0, instr_d = NOP, pc_d = 0, pc_plus_4_d = 4.
  - Storage contents are don't-care.
- imem_addr = fetch PC register (combinational from the register).
- pop = valid_d & ~stall_d.
- push = imem_valid & ~redirect_e & (count < DEPTH | pop).
- On push:
  - Write {imem_addr, imem_rdata} at the write pointer.
  - Advance the write pointer.
  - fetch PC <= fetch PC + 4 (wraps modulo 2^XLEN).
- On pop: advance the read pointer.
- Occupancy: count += push, -= pop. Simultaneous push and pop leaves count unchanged, including when full.
- No push (full without pop, or imem_valid = 0): the fetch PC holds and imem_addr is stable. Memory must keep imem_rdata tied to that address.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- Head outputs:
  - Combinational from the read-pointer entry.
  - valid_d = (count != 0).
  - When empty, drive NOP and hold pc_d at the last popped PC (0 after reset).
- Redirect (redirect_e = 1) has priority over everything:
  - At the edge: count <= 0, pointers <= 0, fetch PC <= {redirect_pc_e[XLEN-1:2], 2'b00}. Misaligned low bits are dropped.
  - No push occurs that cycle. The pop is ignored; the entry is discarded.
  - The next cycle has imem_addr = target and valid_d = 0.
  - The earliest valid_d for the target is 2 cycles after redirect_e, assuming imem_valid = 1. This matches the existing 2-bubble branch penalty.
- Redirect together with stall_d: the redirect wins and the stalled entry is discarded.
- Back-to-back redirects: the last one wins; each restarts from its target.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight entries are lost.
- Steady state with no stalls: a 1-cycle fetch-to-decode latency. An instruction fetched in cycle n is valid at decode in cycle n+1, giving 1 instruction/cycle throughput.

Test Plan:
- Reset release, imem_valid = 1, stall_d = 0:
  - imem_addr sequence 0,4,8,C.
  - valid_d rises 1 cycle after release, with pc_d = 0, pc_plus_4_d = 4, instr_d = word at 0.
  - count stays 1.
- stall_d = 1 for 6 cycles from empty, imem_valid = 1:
  - count 1,2,3,4 then holds 4; imem_addr freezes at 0x10.
  - Head stays pc_d = 0.
  - On release, pops return PCs 0,4,8,C in order, then 0x10.
- Full queue (count = 4), stall_d = 0, imem_valid = 1:
  - Simultaneous push/pop keeps count = 4 over 10 cycles.
  - pc_d increments by 4 each cycle, with no loss or duplication across pointer wrap.
- imem_valid toggled 1,0,0,1:
  - imem_addr holds 4 during wait states.
  - Entries are pushed only on valid cycles, and the decoded PC stream is 0,4,8 with gaps (valid_d = 0) when the queue drains.
- redirect_e = 1, redirect_pc_e = 0x0000_0103 while count = 3 and stall_d = 1:
  - Next cycle: count = 0, valid_d = 0, instr_d = 0x0000_0013, imem_addr = 0x100.
  - Following cycle: valid_d = 1, pc_d = 0x100.
- rst pulsed low for a half cycle while count = 3:
  - Outputs immediately go to reset values (valid_d = 0, imem_addr = RESET_PC) without a clock edge.
  - Fetch resumes at 0 after release.
